// File: rtl/cpu_pkg.sv
// Shared CPU control-path definitions: program-counter operation codes and
// default address geometry for the sequencer/PC datapath.
package cpu_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int RESET_VEC_DEF = 0;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        INC  = 3'd1,
        JMP  = 3'd2,
        JCC  = 3'd3,
        CALL = 3'd4,
        RET  = 3'd5
    } pc_op_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: register array with a depth counter, zero-latency
// top-of-stack read. Push/pop requests against full/empty are ignored.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int DEPTH_W = PTR_W + 1;

    logic [W-1:0]       mem_p0 [DEPTH];
    logic [DEPTH_W-1:0] depth_p0;
    logic [PTR_W-1:0]   wr_idx;
    logic [PTR_W-1:0]   rd_idx;
    logic               do_push;
    logic               do_pop;

    assign full  = (depth_p0 == DEPTH_W'(DEPTH));
    assign empty = (depth_p0 == '0);
    assign depth = depth_p0;

    // When full the low pointer bits wrap to zero, so rd_idx still lands on DEPTH-1.
    assign wr_idx = depth_p0[PTR_W-1:0];
    assign rd_idx = depth_p0[PTR_W-1:0] - PTR_W'(1);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;

    assign top = mem_p0[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_p0 <= '0;
        end else if (do_push) begin
            depth_p0 <= depth_p0 + DEPTH_W'(1);
        end else if (do_pop) begin
            depth_p0 <= depth_p0 - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_p0[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with reset vector, conditional branch and a hardware
// return-address stack; one prioritised action per clock.
module pc_stack
    import cpu_pkg::*;
#(
    parameter int                  ADDR_W      = ADDR_W_DEF,
    parameter int                  STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]   RESET_VEC   = ADDR_W'(RESET_VEC_DEF)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inc,
    input  logic                          jmp,
    input  logic                          jcc,
    input  logic                          cond,
    input  logic                          call,
    input  logic                          ret,
    input  logic                          err_clr,
    input  logic [ADDR_W-1:0]             target,
    output logic [ADDR_W-1:0]             pc,
    output logic [$clog2(STACK_DEPTH):0]  depth,
    output logic                          stk_full,
    output logic                          stk_empty,
    output logic                          ovf_err,
    output logic                          unf_err
);

    if (ADDR_W < 4) begin : g_chk_addr_w
        $error("pc_stack: ADDR_W must be at least 4");
    end
    if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("pc_stack: STACK_DEPTH must be a power of two >= 2");
    end

    function automatic logic [ADDR_W-1:0] pc_plus1(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    logic [ADDR_W-1:0] pc_p0;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] stk_top;
    logic              ovf_p0;
    logic              unf_p0;
    logic              ovf_set;
    logic              unf_set;
    logic              push;
    logic              pop;
    pc_op_e            op;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_plus1(pc_p0)),
        .top   (stk_top),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        op = HOLD;
        if (call) begin
            op = CALL;
        end else if (ret) begin
            op = RET;
        end else if (jmp) begin
            op = JMP;
        end else if (jcc) begin
            op = JCC;
        end else if (inc) begin
            op = INC;
        end
    end

    always_comb begin
        pc_nxt  = pc_p0;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (op)
            CALL: begin
                if (stk_full) begin
                    ovf_set = 1'b1;
                end else begin
                    push   = 1'b1;
                    pc_nxt = target;
                end
            end
            RET: begin
                if (stk_empty) begin
                    unf_set = 1'b1;
                end else begin
                    pop    = 1'b1;
                    pc_nxt = stk_top;
                end
            end
            JMP:     pc_nxt = target;
            JCC:     pc_nxt = cond ? target : pc_plus1(pc_p0);
            INC:     pc_nxt = pc_plus1(pc_p0);
            default: pc_nxt = pc_p0;
        endcase
    end

    // A fresh error in the clearing cycle keeps its flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0  <= RESET_VEC;
            ovf_p0 <= 1'b0;
            unf_p0 <= 1'b0;
        end else begin
            pc_p0  <= pc_nxt;
            ovf_p0 <= ovf_set | (ovf_p0 & ~err_clr);
            unf_p0 <= unf_set | (unf_p0 & ~err_clr);
        end
    end

    assign pc      = pc_p0;
    assign ovf_err = ovf_p0;
    assign unf_err = unf_p0;

endmodule

// File: tb/tb_pc_stack.sv
// Directed, table-driven bench for pc_stack (ADDR_W=8, depth 4, reset vector 8'h10).
module tb_pc_stack;

    localparam logic [7:0] C_RST  = 8'h80;
    localparam logic [7:0] C_CALL = 8'h40;
    localparam logic [7:0] C_RET  = 8'h20;
    localparam logic [7:0] C_JMP  = 8'h10;
    localparam logic [7:0] C_JCC  = 8'h08;
    localparam logic [7:0] C_COND = 8'h04;
    localparam logic [7:0] C_INC  = 8'h02;
    localparam logic [7:0] C_CLR  = 8'h01;

    typedef struct {
        logic [7:0] ctl;
        logic [7:0] tgt;
        logic [7:0] exp_pc;
        logic [2:0] exp_depth;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, inc, jmp, jcc, cond, call, ret, err_clr;
    logic [7:0] target;
    logic [7:0] pc;
    logic [2:0] depth;
    logic       stk_full, stk_empty, ovf_err, unf_err;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_stack #(
        .ADDR_W      (8),
        .STACK_DEPTH (4),
        .RESET_VEC   (8'h10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc),
        .jmp       (jmp),
        .jcc       (jcc),
        .cond      (cond),
        .call      (call),
        .ret       (ret),
        .err_clr   (err_clr),
        .target    (target),
        .pc        (pc),
        .depth     (depth),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    function automatic vec_t v(input logic [7:0] ctl, input logic [7:0] tgt,
                               input logic [7:0] epc, input logic [2:0] ed,
                               input logic eovf, input logic eunf);
        vec_t r;
        r.ctl = ctl; r.tgt = tgt; r.exp_pc = epc;
        r.exp_depth = ed; r.exp_ovf = eovf; r.exp_unf = eunf;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        rst     = t.ctl[7];
        call    = t.ctl[6];
        ret     = t.ctl[5];
        jmp     = t.ctl[4];
        jcc     = t.ctl[3];
        cond    = t.ctl[2];
        inc     = t.ctl[1];
        err_clr = t.ctl[0];
        target  = t.tgt;
        @(posedge clk);
        #1;
        check({tag, " pc"},        32'(pc),        32'(t.exp_pc));
        check({tag, " depth"},     32'(depth),     32'(t.exp_depth));
        check({tag, " stk_full"},  32'(stk_full),  32'(t.exp_depth == 3'd4));
        check({tag, " stk_empty"}, 32'(stk_empty), 32'(t.exp_depth == 3'd0));
        check({tag, " ovf_err"},   32'(ovf_err),   32'(t.exp_ovf));
        check({tag, " unf_err"},   32'(unf_err),   32'(t.exp_unf));
    endtask

    initial begin
        {rst, inc, jmp, jcc, cond, call, ret, err_clr} = '0;
        target = '0;

        // reset and increments
        vecs.push_back(v(C_RST,                 8'h00, 8'h10, 3'd0, 0, 0));
        vecs.push_back(v(C_INC,                 8'h00, 8'h11, 3'd0, 0, 0));
        vecs.push_back(v(C_INC,                 8'h00, 8'h12, 3'd0, 0, 0));
        vecs.push_back(v(C_INC,                 8'h00, 8'h13, 3'd0, 0, 0));
        // wrap
        vecs.push_back(v(C_JMP,                 8'hFF, 8'hFF, 3'd0, 0, 0));
        vecs.push_back(v(C_INC,                 8'h00, 8'h00, 3'd0, 0, 0));
        // conditional branch
        vecs.push_back(v(C_JMP,                 8'h20, 8'h20, 3'd0, 0, 0));
        vecs.push_back(v(C_JCC,                 8'h40, 8'h21, 3'd0, 0, 0));
        vecs.push_back(v(C_JMP,                 8'h20, 8'h20, 3'd0, 0, 0));
        vecs.push_back(v(C_JCC | C_COND,        8'h40, 8'h40, 3'd0, 0, 0));
        // nested calls, overflow, returns
        vecs.push_back(v(C_JMP,                 8'h20, 8'h20, 3'd0, 0, 0));
        vecs.push_back(v(C_CALL,                8'h30, 8'h30, 3'd1, 0, 0));
        vecs.push_back(v(C_CALL,                8'h40, 8'h40, 3'd2, 0, 0));
        vecs.push_back(v(C_CALL,                8'h50, 8'h50, 3'd3, 0, 0));
        vecs.push_back(v(C_CALL,                8'h60, 8'h60, 3'd4, 0, 0));
        vecs.push_back(v(C_CALL,                8'h70, 8'h60, 3'd4, 1, 0));
        vecs.push_back(v(C_RET,                 8'h00, 8'h51, 3'd3, 1, 0));
        vecs.push_back(v(C_RET,                 8'h00, 8'h41, 3'd2, 1, 0));
        vecs.push_back(v(C_RET,                 8'h00, 8'h31, 3'd1, 1, 0));
        vecs.push_back(v(C_RET,                 8'h00, 8'h21, 3'd0, 1, 0));
        vecs.push_back(v(C_CLR,                 8'h00, 8'h21, 3'd0, 0, 0));
        // underflow and sticky clear
        vecs.push_back(v(C_RET,                 8'h00, 8'h21, 3'd0, 0, 1));
        vecs.push_back(v(8'h00,                 8'h00, 8'h21, 3'd0, 0, 1));
        vecs.push_back(v(C_CLR,                 8'h00, 8'h21, 3'd0, 0, 0));
        vecs.push_back(v(C_RET,                 8'h00, 8'h21, 3'd0, 0, 1));
        vecs.push_back(v(C_RET | C_CLR,         8'h00, 8'h21, 3'd0, 0, 1));
        vecs.push_back(v(C_CLR,                 8'h00, 8'h21, 3'd0, 0, 0));
        // priority
        vecs.push_back(v(C_CALL | C_JMP | C_INC, 8'h80, 8'h80, 3'd1, 0, 0));
        vecs.push_back(v(C_RET | C_JMP | C_INC,  8'h99, 8'h22, 3'd0, 0, 0));
        vecs.push_back(v(C_JMP | C_JCC | C_COND | C_INC, 8'h55, 8'h55, 3'd0, 0, 0));
        vecs.push_back(v(C_JCC | C_INC,         8'h77, 8'h56, 3'd0, 0, 0));
        // reset mid call sequence
        vecs.push_back(v(C_CALL,                8'h70, 8'h70, 3'd1, 0, 0));
        vecs.push_back(v(C_CALL,                8'h90, 8'h90, 3'd2, 0, 0));
        vecs.push_back(v(C_RST | C_CALL,        8'h33, 8'h10, 3'd0, 0, 0));
        vecs.push_back(v(8'h00,                 8'h00, 8'h10, 3'd0, 0, 0));
        // back-to-back call/ret
        vecs.push_back(v(C_CALL,                8'hA0, 8'hA0, 3'd1, 0, 0));
        vecs.push_back(v(C_RET,                 8'h00, 8'h11, 3'd0, 0, 0));
        vecs.push_back(v(C_CALL,                8'hB0, 8'hB0, 3'd1, 0, 0));
        vecs.push_back(v(C_CALL,                8'hC0, 8'hC0, 3'd2, 0, 0));
        vecs.push_back(v(C_RET,                 8'h00, 8'hB1, 3'd1, 0, 0));
        vecs.push_back(v(C_RET,                 8'h00, 8'h12, 3'd0, 0, 0));

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // fill the stack, then an overflowing call in the same cycle as err_clr
        apply(v(C_CALL,          8'h20, 8'h20, 3'd1, 0, 0), "ovf fill1");
        apply(v(C_CALL,          8'h30, 8'h30, 3'd2, 0, 0), "ovf fill2");
        apply(v(C_CALL,          8'h40, 8'h40, 3'd3, 0, 0), "ovf fill3");
        apply(v(C_CALL,          8'h50, 8'h50, 3'd4, 0, 0), "ovf fill4");
        apply(v(C_CALL | C_CLR,  8'h60, 8'h50, 3'd4, 1, 0), "ovf clr-race");
        apply(v(C_CLR,           8'h00, 8'h50, 3'd4, 0, 0), "ovf clr");
        apply(v(C_RET,           8'h00, 8'h41, 3'd3, 0, 0), "ovf pop1");
        apply(v(C_RET,           8'h00, 8'h31, 3'd2, 0, 0), "ovf pop2");
        apply(v(C_RET,           8'h00, 8'h21, 3'd1, 0, 0), "ovf pop3");
        apply(v(C_RET,           8'h00, 8'h13, 3'd0, 0, 0), "ovf pop4");

        // return address wraps when calling from the top of the address space
        apply(v(C_RST,           8'h00, 8'h10, 3'd0, 0, 0), "wrap rst");
        apply(v(C_JMP,           8'hFF, 8'hFF, 3'd0, 0, 0), "wrap jmp");
        apply(v(C_CALL,          8'h12, 8'h12, 3'd1, 0, 0), "wrap call");
        apply(v(C_RET,           8'h00, 8'h00, 3'd0, 0, 0), "wrap ret");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
